// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, FSM state type and index decode for irq_pending_8
package irq_pkg;

  localparam int NUM_IRQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  function automatic logic [NUM_IRQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    onehot8 = NUM_IRQ'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_edge_det.sv
// rtl/irq_edge_det.sv - request capture: rising-edge or level set pulses per line
module irq_edge_det
  import irq_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] req,
  output logic [NUM_IRQ-1:0] set
);

  logic [NUM_IRQ-1:0] req_q;

  // req_q resets low so a line already high at reset release reads as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req;
    end
  end

  always_comb begin
    set = EDGE_MODE ? (req & ~req_q) : req;
  end

endmodule

// File: rtl/irq_pending_8.sv
// rtl/irq_pending_8.sv - pending/overflow capture and frozen snapshot handshake for the priority encoder
module irq_pending_8
  import irq_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] vec,
  output logic               vec_valid,
  input  logic               vec_ready,
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] ovf,
  input  logic               ovf_clr,
  output logic               err
);

  state_t             state;
  state_t             state_nxt;
  logic [NUM_IRQ-1:0] set;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] ovf_new;
  logic [NUM_IRQ-1:0] avail;
  logic               hs;
  logic               hit;

  irq_edge_det #(
    .EDGE_MODE(EDGE_MODE)
  ) u_edge_det (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .set  (set)
  );

  assign avail = pending & mask;
  assign hs    = vec_valid & vec_ready;
  assign hit   = vec[idx];

  always_comb begin
    clr     = (hs && hit) ? onehot8(idx) : '0;
    ovf_new = EDGE_MODE ? (set & pending & ~clr) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|avail) state_nxt = VALID;
      VALID:   if (vec_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vec_valid = (state == VALID);
  end

  // set is OR-ed after the clear so a same-cycle re-request keeps the bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ovf     <= '0;
      vec     <= '0;
      err     <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | set;
      ovf     <= (ovf_clr ? '0 : ovf) | ovf_new;
      err     <= hs & ~hit;
      if (state == IDLE && |avail) begin
        vec <= avail;
      end
    end
  end

endmodule
